// File: rtl/debounce_pkg.sv
// Shared encodings and defaults for the input debounce slice.
// The optional rise/fall edge pulses are controlled by the macro DEBOUNCE_EDGE_EN.
package debounce_pkg;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } db_state_t;

   localparam int DEFAULT_STABLE_CYCLES = 50000;
   localparam int DEFAULT_CNT_W         = 16;

   // The counter tops out at stable_cycles-1, so that value must fit in cnt_w bits.
   function automatic bit cfg_ok(input int cnt_w, input int stable_cycles);
      return (stable_cycles >= 1) &&
             ((longint'(stable_cycles) - 64'sd1) < (longint'(1) << cnt_w));
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: 2-flop synchroniser, stability FSM/counter, registered pulses.
// With DEBOUNCE_EDGE_EN defined the rise/fall flops are built, otherwise rise/fall tie to 0.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_STABLE  | synchronised input matches clean; counter parked at 0
//   ST_PENDING | new level seen; counting consecutive clocks it has held
module debounce_bit
   import debounce_pkg::*;
#(
   parameter int CNT_W         = DEFAULT_CNT_W,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean,
   output logic changed,
   output logic rise,
   output logic fall
);

   if (!cfg_ok(CNT_W, STABLE_CYCLES)) begin : g_bad_cfg
      $error("debounce_bit: STABLE_CYCLES must be >= 1 and STABLE_CYCLES-1 must fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1;
   logic             s2;
   db_state_t        state;
   db_state_t        state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             clean_nx;
   logic             upd;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      clean_nx = clean;
      upd      = 1'b0;
      unique case (state)
         ST_STABLE: begin
            cnt_nx = '0;
            if (s2 != clean) begin
               // A single-cycle requirement is already met by the first differing sample.
               if (STABLE_CYCLES == 1) begin
                  clean_nx = s2;
                  upd      = 1'b1;
               end else begin
                  state_nx = ST_PENDING;
                  cnt_nx   = CNT_ONE;
               end
            end
         end
         ST_PENDING: begin
            if (s2 == clean) begin
               state_nx = ST_STABLE;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               clean_nx = s2;
               upd      = 1'b1;
               cnt_nx   = '0;
               state_nx = ST_STABLE;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nx = ST_STABLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         state   <= ST_STABLE;
         cnt     <= '0;
         clean   <= 1'b0;
         changed <= 1'b0;
      end else begin
         s1      <= raw;
         s2      <= s1;
         state   <= state_nx;
         cnt     <= cnt_nx;
         clean   <= clean_nx;
         changed <= upd;
      end
   end

`ifdef DEBOUNCE_EDGE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= upd & clean_nx;
         fall <= upd & ~clean_nx;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debounce.sv
// Debounces WIDTH independent switch lines into clock-synchronous levels (bit0->a, bit1->b, bit2->c).
// rise/fall pulses exist only when DEBOUNCE_EDGE_EN is defined; the port list never changes.
module input_debounce
   import debounce_pkg::*;
#(
   parameter int WIDTH         = 3,
   parameter int CNT_W         = DEFAULT_CNT_W,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] clean,
   output logic             changed,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] changed_bit;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .CNT_W         (CNT_W),
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .rst     (rst),
         .raw     (raw[i]),
         .clean   (clean[i]),
         .changed (changed_bit[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   // Per-bit flags are already registered, so the OR keeps the one-clock pulse shape.
   assign changed = |changed_bit;

endmodule
